conv_feed_sequencer: RTL and testbench

- Job sequencer placed directly upstream of the ConvolutionAccelerator.
- Accepts operand words from the processing-system stream and writes them into the accelerator input FIFO with backpressure from FULL.
- Fires cStart once a full operand set is loaded, waits for cReady, then captures finalsum and presents it to the processor through a valid/ready result port.
- Times out and flags an error if the accelerator never responds.

---
 rtl/conv_feed_sequencer.sv | 134 +++++++++++++
 tb/tb_conv_feed_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_feed_sequencer.sv
// Job sequencer in front of the convolution accelerator: streams operands into its input FIFO,
// kicks off a compute, waits for the result and hands it to the processor over valid/ready.
module conv_feed_sequencer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LOAD_WORDS  = 18,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              go,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] dataInput,
  output logic              wr,
  input  logic              FULL,
  input  logic              EMPTY,
  output logic              cStart,
  input  logic              cReady,
  input  logic [DATA_W-1:0] finalsum,
  output logic              r_valid,
  output logic [DATA_W-1:0] r_data,
  input  logic              r_ready,
  output logic              busy,
  output logic              err_timeout,
  output logic [7:0]        words_loaded,
  output logic              fifo_empty
);

  localparam int unsigned      TimerW    = $clog2(TIMEOUT_CYC);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]        LastWord  = 8'(LOAD_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StOut
  } state_e;

  state_e              r_state;
  logic [DATA_W-1:0]   r_data_in;
  logic                r_wr;
  logic                r_cstart;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [7:0]          r_words;
  logic                r_fifo_empty;
  logic [TimerW-1:0]   r_timer;
  logic                r_cready_prev;

  logic w_hs;
  logic w_cready_rise;

  assign s_ready       = (r_state == StLoad) && !FULL;
  assign w_hs          = s_valid && s_ready;
  // Only a fresh edge counts, so a level left high by an earlier job cannot complete this one.
  assign w_cready_rise = cReady && !r_cready_prev;

  always_ff @(posedge Clk) begin
    r_cready_prev <= cReady;
    if (!Rst) begin
      r_state      <= StIdle;
      r_data_in    <= '0;
      r_wr         <= 1'b0;
      r_cstart     <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_words      <= '0;
      r_fifo_empty <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_wr         <= 1'b0;
      r_cstart     <= 1'b0;
      r_fifo_empty <= EMPTY;
      case (r_state)
        StIdle: begin
          if (go) begin
            r_words <= '0;
            r_err   <= 1'b0;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          if (w_hs) begin
            r_data_in <= s_data;
            r_wr      <= 1'b1;
            r_words   <= r_words + 8'd1;
            if (r_words == LastWord) r_state <= StStart;
          end
        end
        StStart: begin
          r_cstart <= 1'b1;
          r_timer  <= '0;
          r_state  <= StWait;
        end
        StWait: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (w_cready_rise) begin
            r_rdata  <= finalsum;
            r_rvalid <= 1'b1;
            r_state  <= StOut;
          end else if (r_timer == TimerLast) begin
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_timer <= r_timer + TimerW'(1);
          end
        end
        StOut: begin
          if (r_ready) begin
            r_rvalid <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dataInput    = r_data_in;
  assign wr           = r_wr;
  assign cStart       = r_cstart;
  assign r_valid      = r_rvalid;
  assign r_data       = r_rdata;
  assign err_timeout  = r_err;
  assign words_loaded = r_words;
  assign fifo_empty   = r_fifo_empty;
  assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_conv_feed_sequencer.sv
// Bench for conv_feed_sequencer: a table of jobs plus random jobs, each checked cycle by cycle
// against expectations derived from the job description and the stimulus actually driven.
module tb_conv_feed_sequencer;

  localparam int DW = 16;
  localparam int LW = 18;
  localparam int TO = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          go;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [DW-1:0] dataInput;
  logic          wr;
  logic          FULL;
  logic          EMPTY;
  logic          cStart;
  logic          cReady;
  logic [DW-1:0] finalsum;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_ready;
  logic          busy;
  logic          err_timeout;
  logic [7:0]    words_loaded;
  logic          fifo_empty;

  int n_checks = 0;
  int n_err    = 0;

  conv_feed_sequencer #(
    .DATA_W     (DW),
    .LOAD_WORDS (LW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .go          (go),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .dataInput   (dataInput),
    .wr          (wr),
    .FULL        (FULL),
    .EMPTY       (EMPTY),
    .cStart      (cStart),
    .cReady      (cReady),
    .finalsum    (finalsum),
    .r_valid     (r_valid),
    .r_data      (r_data),
    .r_ready     (r_ready),
    .busy        (busy),
    .err_timeout (err_timeout),
    .words_loaded(words_loaded),
    .fifo_empty  (fifo_empty)
  );

  always #5 Clk = ~Clk;

  // One job: stall pattern, accelerator response delay after cStart (-1 = never), result
  // consumer delay, and the expected outcome.
  typedef struct {
    int          full_at;
    int          full_len;
    bit          rnd;
    int          cdelay;
    bit          stale;
    int          rdelay;
    bit          go_out;
    logic [15:0] fsum;
    bit          exp_err;
  } job_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: cycle budget expired at %0t", name, $time);
    Rst = 1'b0; go = 1'b0; s_valid = 1'b0; r_ready = 1'b0; cReady = 1'b0; FULL = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic run_job(input job_t j);
    logic [DW-1:0] words [LW];
    logic [DW-1:0] hs_word;
    logic          last_empty;
    bit            hs_prev;
    bit            ended;
    int            acc, cyc, full_left, done_k, to_k;

    for (int i = 0; i < LW; i++) words[i] = j.rnd ? DW'($urandom) : DW'(i + 1);
    hs_word = '0;
    cReady   = j.stale;
    finalsum = ~j.fsum;
    go = 1'b1;
    @(negedge Clk);
    go = 1'b0;
    check("go_busy", 32'(busy), 32'(1));
    check("go_err_clear", 32'(err_timeout), 32'(0));

    acc = 0; cyc = 0; hs_prev = 1'b0; full_left = j.full_len; last_empty = EMPTY;
    forever begin
      check("wr", 32'(wr), 32'(hs_prev));
      if (hs_prev) check("dataInput", 32'(dataInput), 32'(hs_word));
      check("words_loaded", 32'(words_loaded), 32'(acc));
      check("cStart_load", 32'(cStart), 32'(0));
      check("fifo_empty", 32'(fifo_empty), 32'(last_empty));
      if (acc == LW) break;
      if (cyc++ > 400) begin
        expire("load_budget");
        return;
      end
      s_valid = j.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (j.rnd) FULL = ($urandom_range(0, 3) == 0);
      else if (acc + 1 == j.full_at && full_left > 0) begin
        FULL = 1'b1;
        full_left--;
      end else FULL = 1'b0;
      s_data = s_valid ? words[acc] : DW'($urandom);
      EMPTY = 1'($urandom_range(0, 1));
      last_empty = EMPTY;
      #1;
      check("s_ready", 32'(s_ready), 32'(!FULL));
      hs_prev = s_valid && !FULL;
      if (hs_prev) begin
        hs_word = words[acc];
        acc++;
      end
      @(negedge Clk);
    end
    s_valid = 1'b0;
    FULL = 1'b0;
    check("busy_start", 32'(busy), 32'(1));

    done_k = j.exp_err ? -1 : j.cdelay + 1;
    to_k   = j.exp_err ? TO : -1;
    ended  = 1'b0;
    for (int k = 0; k <= TO + 1; k++) begin
      @(negedge Clk);
      check("cStart", 32'(cStart), 32'(k == 0));
      check("wr_wait", 32'(wr), 32'(0));
      check("r_valid_wait", 32'(r_valid), 32'(k == done_k));
      check("err_timeout", 32'(err_timeout), 32'(k == to_k));
      check("busy_wait", 32'(busy), 32'(k != to_k));
      if (k == done_k) begin
        check("r_data", 32'(r_data), 32'(j.fsum));
        ended = 1'b1;
        break;
      end
      if (k == to_k) begin
        ended = 1'b1;
        break;
      end
      if (j.stale && k == 1) cReady = 1'b0;
      if (k == j.cdelay) begin
        cReady   = 1'b1;
        finalsum = j.fsum;
      end else finalsum = ~j.fsum;
    end
    if (!ended) begin
      expire("wait_budget");
      return;
    end

    if (j.exp_err) begin
      cReady = 1'b0;
      @(negedge Clk);
      check("err_sticky", 32'(err_timeout), 32'(1));
      check("r_valid_after_to", 32'(r_valid), 32'(0));
      return;
    end

    for (int i = 0; i <= j.rdelay; i++) begin
      if (i > 0) begin
        @(negedge Clk);
        check("r_valid_hold", 32'(r_valid), 32'(1));
        check("r_data_hold", 32'(r_data), 32'(j.fsum));
        check("busy_out", 32'(busy), 32'(1));
        check("words_out", 32'(words_loaded), 32'(LW));
      end
      finalsum = DW'($urandom);
      go = j.go_out && (i == 1);
      r_ready = (i == j.rdelay);
    end
    @(negedge Clk);
    r_ready = 1'b0;
    go = 1'b0;
    cReady = 1'b0;
    check("r_valid_done", 32'(r_valid), 32'(0));
    check("busy_done", 32'(busy), 32'(0));
    @(negedge Clk);
    check("idle_stays", 32'(busy), 32'(0));
  endtask

  job_t tbl[9];
  job_t rj;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // full_at full_len rnd cdelay stale rdelay go_out fsum exp_err
    tbl[0] = '{0, 0, 1'b0,  5, 1'b0,  0, 1'b0, 16'h0123, 1'b0};  // basic
    tbl[1] = '{7, 3, 1'b0,  3, 1'b0,  1, 1'b0, 16'hBEEF, 1'b0};  // backpressure
    tbl[2] = '{0, 0, 1'b0, -1, 1'b0,  0, 1'b0, 16'h0000, 1'b1};  // no response
    tbl[3] = '{0, 0, 1'b0,  2, 1'b0,  0, 1'b0, 16'h5A5A, 1'b0};  // clears err
    tbl[4] = '{0, 0, 1'b0,  6, 1'b1,  0, 1'b0, 16'h0F0F, 1'b0};  // stale ready
    tbl[5] = '{0, 0, 1'b0,  4, 1'b0, 20, 1'b1, 16'h7777, 1'b0};  // result stall + go
    tbl[6] = '{0, 0, 1'b0, 15, 1'b0,  0, 1'b0, 16'h1357, 1'b0};  // edge meets timeout
    tbl[7] = '{0, 0, 1'b0, 16, 1'b0,  0, 1'b0, 16'h2222, 1'b1};  // edge one too late
    tbl[8] = '{0, 0, 1'b0,  0, 1'b0,  2, 1'b0, 16'h2468, 1'b0};  // immediate ready

    Rst = 1'b0; go = 1'b1; s_valid = 1'b1; s_data = 16'hFFFF; FULL = 1'b0; EMPTY = 1'b1;
    cReady = 1'b0; finalsum = 16'hFFFF; r_ready = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_wr", 32'(wr), 32'(0));
    check("rst_cStart", 32'(cStart), 32'(0));
    check("rst_r_valid", 32'(r_valid), 32'(0));
    check("rst_r_data", 32'(r_data), 32'(0));
    check("rst_dataInput", 32'(dataInput), 32'(0));
    check("rst_err", 32'(err_timeout), 32'(0));
    check("rst_words", 32'(words_loaded), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_fifo_empty", 32'(fifo_empty), 32'(0));
    Rst = 1'b1; go = 1'b0; s_valid = 1'b0; r_ready = 1'b1;
    @(negedge Clk);
    check("fifo_empty_follow", 32'(fifo_empty), 32'(1));
    check("idle_r_ready", 32'(r_valid), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
    r_ready = 1'b0; EMPTY = 1'b0;
    @(negedge Clk);

    for (int t = 0; t < 9; t++) run_job(tbl[t]);

    // Abort a job after ten words.
    go = 1'b1;
    @(negedge Clk);
    go = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(100 + i);
      @(negedge Clk);
    end
    check("mid_wr", 32'(wr), 32'(1));
    check("mid_data", 32'(dataInput), 32'(109));
    check("mid_words", 32'(words_loaded), 32'(10));
    Rst = 1'b0;
    @(negedge Clk);
    check("abort_wr", 32'(wr), 32'(0));
    check("abort_cStart", 32'(cStart), 32'(0));
    check("abort_words", 32'(words_loaded), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    Rst = 1'b1;
    s_valid = 1'b0;
    @(negedge Clk);
    check("post_abort_wr", 32'(wr), 32'(0));
    check("post_abort_busy", 32'(busy), 32'(0));
    run_job(tbl[0]);

    for (int n = 0; n < 20; n++) begin
      rj.full_at  = 0;
      rj.full_len = 0;
      rj.rnd      = 1'b1;
      rj.cdelay   = $urandom_range(0, TO + 1);
      rj.stale    = (rj.cdelay >= 2) && ($urandom_range(0, 1) == 1);
      rj.rdelay   = $urandom_range(0, 3);
      rj.go_out   = ($urandom_range(0, 1) == 1);
      rj.fsum     = 16'($urandom);
      rj.exp_err  = (rj.cdelay > TO - 1);
      run_job(rj);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
